// File: rtl/apb_arb_pkg.sv
// Shared types and default widths for the two-requester APB master arbiter.
package apb_arb_pkg;

  localparam int unsigned DefAddrWidth = 16;
  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefTimeout   = 255;
  localparam int unsigned StrbWidth    = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StSetup  = 2'b01,
    StAccess = 2'b10
  } state_e;

endpackage

// File: rtl/apb_master_arbiter_if.sv
// APB bus bundle between the arbiter (master side) and a single APB slave.
interface apb_master_arbiter_if
  import apb_arb_pkg::*;
#(
  parameter int unsigned ADDRWIDTH = DefAddrWidth,
  parameter int unsigned DATAWIDTH = DefDataWidth
) ();

  logic                 PSEL;
  logic                 PENABLE;
  logic                 PWRITE;
  logic [ADDRWIDTH-1:0] PADDR;
  logic [DATAWIDTH-1:0] PWDATA;
  logic [StrbWidth-1:0] PSTRB;
  logic [DATAWIDTH-1:0] PRDATA;
  logic                 PREADY;
  logic                 PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin arbiter; the pointer records the most recently granted requester.
module apb_rr_arbiter (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  output logic [1:0] grant_o
);

  logic last_q, last_d;

  always_comb begin
    grant_o = 2'b00;
    unique case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

  // The caller only presents requests when it will take the grant, so any grant moves the pointer.
  always_comb begin
    last_d = last_q;
    if (|grant_o) begin
      last_d = grant_o[1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port between two requesters with round-robin arbitration,
// back-to-back handover, PCLKEN qualification and an optional wait-state timeout.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned ADDRWIDTH = DefAddrWidth,
  parameter int unsigned DATAWIDTH = DefDataWidth,
  parameter int unsigned TIMEOUT   = DefTimeout
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 PCLKEN,
  input  logic                 REQ0_VALID,
  input  logic [ADDRWIDTH-1:0] REQ0_ADDR,
  input  logic                 REQ0_WRITE,
  input  logic [DATAWIDTH-1:0] REQ0_WDATA,
  input  logic [StrbWidth-1:0] REQ0_STRB,
  output logic                 REQ0_READY,
  output logic [DATAWIDTH-1:0] REQ0_RDATA,
  output logic                 REQ0_ERR,
  input  logic                 REQ1_VALID,
  input  logic [ADDRWIDTH-1:0] REQ1_ADDR,
  input  logic                 REQ1_WRITE,
  input  logic [DATAWIDTH-1:0] REQ1_WDATA,
  input  logic [StrbWidth-1:0] REQ1_STRB,
  output logic                 REQ1_READY,
  output logic [DATAWIDTH-1:0] REQ1_RDATA,
  output logic                 REQ1_ERR,
  apb_master_arbiter_if.master apb,
  output logic [1:0]           GRANT,
  output logic                 BUSY
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e               state_q, state_d;
  logic [1:0]           owner_q, owner_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDRWIDTH-1:0] paddr_q, paddr_d;
  logic [DATAWIDTH-1:0] pwdata_q, pwdata_d;
  logic [StrbWidth-1:0] pstrb_q, pstrb_d;
  logic [1:0]           ready_q, ready_d, err_q, err_d;
  logic [DATAWIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic [1:0]           valid, arb_req, arb_grant;
  logic                 in_access, done_ok, timed_out, complete, load, done_err;
  logic [DATAWIDTH-1:0] done_rdata;
  logic [ADDRWIDTH-1:0] sel_addr;
  logic                 sel_write;
  logic [DATAWIDTH-1:0] sel_wdata;
  logic [StrbWidth-1:0] sel_strb;

  assign valid     = {REQ1_VALID, REQ0_VALID};
  assign in_access = (state_q == StAccess) && PCLKEN;
  assign done_ok   = in_access && apb.PREADY;
  assign timed_out = in_access && !apb.PREADY && (TIMEOUT != 0) &&
                     (cnt_q == CntW'(TIMEOUT - 1));
  assign complete  = done_ok || timed_out;

  // The finishing owner is masked out so only the other requester can take a back-to-back slot.
  always_comb begin
    arb_req = 2'b00;
    if ((state_q == StIdle) && PCLKEN) begin
      arb_req = valid;
    end else if (complete) begin
      arb_req = valid & ~owner_q;
    end
  end

  apb_rr_arbiter u_rr_arbiter (
    .clk_i   (HCLK),
    .rst_ni  (HRESETn),
    .req_i   (arb_req),
    .grant_o (arb_grant)
  );

  assign load       = |arb_grant;
  assign sel_addr   = arb_grant[1] ? REQ1_ADDR  : REQ0_ADDR;
  assign sel_write  = arb_grant[1] ? REQ1_WRITE : REQ0_WRITE;
  assign sel_wdata  = arb_grant[1] ? REQ1_WDATA : REQ0_WDATA;
  assign sel_strb   = arb_grant[1] ? REQ1_STRB  : REQ0_STRB;
  assign done_rdata = (done_ok && !pwrite_q) ? apb.PRDATA : '0;
  assign done_err   = done_ok ? apb.PSLVERR : 1'b1;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    ready_d   = 2'b00;
    err_d     = 2'b00;
    rdata0_d  = '0;
    rdata1_d  = '0;

    unique case (state_q)
      StIdle: begin
        state_d = StIdle;
      end
      StSetup: begin
        if (PCLKEN) begin
          state_d   = StAccess;
          penable_d = 1'b1;
        end
      end
      StAccess: begin
        if (complete) begin
          ready_d   = owner_q;
          err_d     = owner_q & {2{done_err}};
          rdata0_d  = owner_q[0] ? done_rdata : '0;
          rdata1_d  = owner_q[1] ? done_rdata : '0;
          cnt_d     = '0;
          state_d   = StIdle;
          psel_d    = 1'b0;
          penable_d = 1'b0;
        end else if (in_access && (TIMEOUT != 0)) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (load) begin
      state_d   = StSetup;
      owner_d   = arb_grant;
      cnt_d     = '0;
      psel_d    = 1'b1;
      penable_d = 1'b0;
      pwrite_d  = sel_write;
      paddr_d   = sel_addr & ~ADDRWIDTH'(3);
      pwdata_d  = sel_wdata;
      pstrb_d   = sel_write ? sel_strb : '0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q   <= StIdle;
      owner_q   <= 2'b00;
      cnt_q     <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      ready_q   <= 2'b00;
      err_q     <= 2'b00;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign apb.PSEL    = psel_q;
  assign apb.PENABLE = penable_q;
  assign apb.PWRITE  = pwrite_q;
  assign apb.PADDR   = paddr_q;
  assign apb.PWDATA  = pwdata_q;
  assign apb.PSTRB   = pstrb_q;

  assign REQ0_READY = ready_q[0];
  assign REQ1_READY = ready_q[1];
  assign REQ0_ERR   = err_q[0];
  assign REQ1_ERR   = err_q[1];
  assign REQ0_RDATA = rdata0_q;
  assign REQ1_RDATA = rdata1_q;

  assign BUSY  = (state_q != StIdle);
  assign GRANT = (state_q == StIdle) ? 2'b00 : owner_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: directed scenarios plus a randomized run against a
// transaction-level reference model of arbitration, handover, waits and timeout.
module tb_apb_master_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          PCLKEN = 1'b0;
  logic [1:0]    valid = 2'b00;
  logic [AW-1:0] addr[2];
  logic          wr[2];
  logic [DW-1:0] wdata[2];
  logic [3:0]    strb[2];
  logic [1:0]    ready;
  logic [DW-1:0] rdata[2];
  logic [1:0]    err;
  logic [1:0]    GRANT;
  logic          BUSY;
  logic [4:0]    ctl;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state
  int            m_phase, m_owner, m_last, m_wait;
  logic [1:0]    m_ready;
  logic [DW-1:0] m_rdata;
  logic          m_err;

  apb_master_arbiter_if #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) apb ();

  apb_master_arbiter #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .TIMEOUT(TO)) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .PCLKEN     (PCLKEN),
    .REQ0_VALID (valid[0]),
    .REQ0_ADDR  (addr[0]),
    .REQ0_WRITE (wr[0]),
    .REQ0_WDATA (wdata[0]),
    .REQ0_STRB  (strb[0]),
    .REQ0_READY (ready[0]),
    .REQ0_RDATA (rdata[0]),
    .REQ0_ERR   (err[0]),
    .REQ1_VALID (valid[1]),
    .REQ1_ADDR  (addr[1]),
    .REQ1_WRITE (wr[1]),
    .REQ1_WDATA (wdata[1]),
    .REQ1_STRB  (strb[1]),
    .REQ1_READY (ready[1]),
    .REQ1_RDATA (rdata[1]),
    .REQ1_ERR   (err[1]),
    .apb        (apb),
    .GRANT      (GRANT),
    .BUSY       (BUSY)
  );

  always #5 HCLK = ~HCLK;

  // {PSEL, PENABLE, GRANT[1:0], BUSY}
  assign ctl = {apb.PSEL, apb.PENABLE, GRANT, BUSY};

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic clear_inputs();
    valid = 2'b00;
    for (int n = 0; n < 2; n++) begin
      addr[n] = '0; wr[n] = 1'b0; wdata[n] = '0; strb[n] = '0;
    end
    apb.PREADY = 1'b0; apb.PSLVERR = 1'b0; apb.PRDATA = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    HRESETn = 1'b0;
    step();
    step();
    HRESETn = 1'b1;
  endtask

  // One HCLK edge of the specified behaviour, at transaction level.
  task automatic model_step(input logic en, input logic [1:0] v, input logic rdy,
                            input logic slverr, input logic [DW-1:0] prd);
    m_ready = 2'b00;
    if (!en) return;
    if (m_phase == 0) begin
      if (v != 2'b00) begin
        m_owner = (v == 2'b11) ? 1 - m_last : (v[1] ? 1 : 0);
        m_last = m_owner; m_phase = 1; m_wait = 0;
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (rdy || (m_wait + 1 == int'(TO))) begin
      m_ready[m_owner] = 1'b1;
      m_rdata = (rdy && !wr[m_owner]) ? prd : '0;
      m_err = rdy ? slverr : 1'b1;
      m_wait = 0;
      if (v[1 - m_owner]) begin
        m_owner = 1 - m_owner; m_last = m_owner; m_phase = 1;
      end else begin
        m_phase = 0;
      end
    end else begin
      m_wait++;
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    valid = 2'b11; PCLKEN = 1'b0;
    HRESETn = 1'b0;
    step();
    step();
    n_checks++; if (ctl !== 5'b00000) begin n_fail++; $display("FAIL rst_ctl got=%b exp=00000", ctl); end
    n_checks++; if (ready !== 2'b00) begin n_fail++; $display("FAIL rst_ready got=%b exp=00", ready); end
    n_checks++; if (err !== 2'b00) begin n_fail++; $display("FAIL rst_err got=%b exp=00", err); end
    n_checks++; if (apb.PADDR !== 16'h0) begin n_fail++; $display("FAIL rst_paddr got=%h exp=0", apb.PADDR); end
    n_checks++; if (apb.PSTRB !== 4'h0 || apb.PWRITE !== 1'b0) begin
      n_fail++; $display("FAIL rst_pstrb_pwrite got=%h/%b exp=0/0", apb.PSTRB, apb.PWRITE);
    end
    clear_inputs();
    HRESETn = 1'b1;
  endtask

  task automatic test_single_read();
    do_reset();
    PCLKEN = 1'b1; apb.PREADY = 1'b1; apb.PRDATA = 32'hCAFE0001;
    valid[0] = 1'b1; addr[0] = 16'h0013; wr[0] = 1'b0;
    step();
    n_checks++; if (ctl !== 5'b10011) begin n_fail++; $display("FAIL rd_setup got=%b exp=10011", ctl); end
    n_checks++; if (apb.PADDR !== 16'h0010) begin n_fail++; $display("FAIL rd_paddr got=%h exp=0010", apb.PADDR); end
    n_checks++; if (apb.PSTRB !== 4'h0) begin n_fail++; $display("FAIL rd_pstrb got=%h exp=0", apb.PSTRB); end
    step();
    n_checks++; if (ctl !== 5'b11011) begin n_fail++; $display("FAIL rd_access got=%b exp=11011", ctl); end
    n_checks++; if (ready !== 2'b00) begin n_fail++; $display("FAIL rd_early_ready got=%b exp=00", ready); end
    step();
    n_checks++; if (ready !== 2'b01) begin n_fail++; $display("FAIL rd_ready got=%b exp=01", ready); end
    n_checks++; if (rdata[0] !== 32'hCAFE0001) begin n_fail++; $display("FAIL rd_rdata got=%h exp=cafe0001", rdata[0]); end
    n_checks++; if (err[0] !== 1'b0) begin n_fail++; $display("FAIL rd_err got=%b exp=0", err[0]); end
    n_checks++; if (ctl !== 5'b00000) begin n_fail++; $display("FAIL rd_idle got=%b exp=00000", ctl); end
    valid[0] = 1'b0;
    step();
    n_checks++; if (ready !== 2'b00) begin n_fail++; $display("FAIL rd_pulse_len got=%b exp=00", ready); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    PCLKEN = 1'b1; apb.PREADY = 1'b1;
    valid = 2'b11;
    addr[0] = 16'h0100; wr[0] = 1'b1; wdata[0] = 32'h11111111; strb[0] = 4'h3;
    addr[1] = 16'h0206; wr[1] = 1'b1; wdata[1] = 32'h22222222; strb[1] = 4'hC;
    step();
    n_checks++; if (ctl !== 5'b10011) begin n_fail++; $display("FAIL b2b_setup0 got=%b exp=10011", ctl); end
    n_checks++; if (apb.PSTRB !== 4'h3 || apb.PWDATA !== 32'h11111111 || apb.PWRITE !== 1'b1) begin
      n_fail++; $display("FAIL b2b_pay0 got=%h/%h/%b exp=3/11111111/1", apb.PSTRB, apb.PWDATA, apb.PWRITE);
    end
    step();
    n_checks++; if (ctl !== 5'b11011) begin n_fail++; $display("FAIL b2b_access0 got=%b exp=11011", ctl); end
    step();
    n_checks++; if (ready !== 2'b01 || rdata[0] !== 32'h0) begin
      n_fail++; $display("FAIL b2b_done0 got=%b/%h exp=01/0", ready, rdata[0]);
    end
    n_checks++; if (ctl !== 5'b10101) begin n_fail++; $display("FAIL b2b_setup1 got=%b exp=10101", ctl); end
    n_checks++; if (apb.PSTRB !== 4'hC || apb.PADDR !== 16'h0204 || apb.PWDATA !== 32'h22222222) begin
      n_fail++; $display("FAIL b2b_pay1 got=%h/%h/%h exp=c/0204/22222222", apb.PSTRB, apb.PADDR, apb.PWDATA);
    end
    valid[0] = 1'b0;
    apb.PSLVERR = 1'b1;
    step();
    n_checks++; if (ctl !== 5'b11101) begin n_fail++; $display("FAIL b2b_access1 got=%b exp=11101", ctl); end
    step();
    n_checks++; if (ready !== 2'b10 || err[1] !== 1'b1) begin
      n_fail++; $display("FAIL b2b_done1 got=%b/%b exp=10/1", ready, err[1]);
    end
    n_checks++; if (ctl !== 5'b00000) begin n_fail++; $display("FAIL b2b_idle got=%b exp=00000", ctl); end
    valid[1] = 1'b0; apb.PSLVERR = 1'b0;
    step();
  endtask

  task automatic test_pclken_stall();
    int e;
    logic [4:0] exp_ctl;
    logic [1:0] exp_rdy;
    do_reset();
    valid[1] = 1'b1; addr[1] = 16'h0AA8; wr[1] = 1'b0; apb.PRDATA = 32'h5A5A0F0F;
    e = 0;
    for (int i = 0; i < 12; i++) begin
      PCLKEN = (i % 2 == 0);
      apb.PREADY = (e == 5);
      step();
      if (PCLKEN) e++;
      exp_ctl = (e == 1) ? 5'b10101 : ((e >= 2 && e <= 5) ? 5'b11101 : 5'b00000);
      exp_rdy = (e == 6 && PCLKEN) ? 2'b10 : 2'b00;
      n_checks++; if (ctl !== exp_ctl) begin
        n_fail++; $display("FAIL stall_ctl i=%0d got=%b exp=%b", i, ctl, exp_ctl);
      end
      n_checks++; if (ready !== exp_rdy) begin
        n_fail++; $display("FAIL stall_ready i=%0d got=%b exp=%b", i, ready, exp_rdy);
      end
      if (e >= 1 && e <= 5) begin
        n_checks++; if (apb.PADDR !== 16'h0AA8) begin
          n_fail++; $display("FAIL stall_paddr i=%0d got=%h exp=0aa8", i, apb.PADDR);
        end
      end
      if (exp_rdy == 2'b10) begin
        n_checks++; if (rdata[1] !== 32'h5A5A0F0F) begin
          n_fail++; $display("FAIL stall_rdata got=%h exp=5a5a0f0f", rdata[1]);
        end
      end
      if (e == 6) valid[1] = 1'b0;
    end
  endtask

  task automatic test_timeout();
    do_reset();
    PCLKEN = 1'b1; apb.PREADY = 1'b0; apb.PRDATA = 32'hDEADBEEF;
    valid[0] = 1'b1; addr[0] = 16'h0040; wr[0] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      n_checks++; if (ctl !== ((k == 1) ? 5'b10011 : 5'b11011) || ready !== 2'b00) begin
        n_fail++; $display("FAIL to_wait k=%0d got=%b/%b exp=%b/00", k, ctl, ready,
                           (k == 1) ? 5'b10011 : 5'b11011);
      end
    end
    step();
    n_checks++; if (ready !== 2'b01 || err[0] !== 1'b1 || rdata[0] !== 32'h0) begin
      n_fail++; $display("FAIL to_done got=%b/%b/%h exp=01/1/0", ready, err[0], rdata[0]);
    end
    n_checks++; if (ctl !== 5'b00000) begin n_fail++; $display("FAIL to_idle got=%b exp=00000", ctl); end
    valid[0] = 1'b0;
    step();
    n_checks++; if (ctl !== 5'b00000 || ready !== 2'b00) begin
      n_fail++; $display("FAIL to_after got=%b/%b exp=00000/00", ctl, ready);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    PCLKEN = 1'b1; apb.PREADY = 1'b1;
    valid[0] = 1'b1; addr[0] = 16'h0008; wr[0] = 1'b1; wdata[0] = 32'h0000ABCD; strb[0] = 4'hF;
    step(); step(); step();
    valid[0] = 1'b0; wr[0] = 1'b0; apb.PREADY = 1'b0;
    step();
    valid[0] = 1'b1;
    step(); step();
    n_checks++; if (ctl !== 5'b11011) begin n_fail++; $display("FAIL rm_access got=%b exp=11011", ctl); end
    HRESETn = 1'b0;
    step();
    n_checks++; if (ctl !== 5'b00000 || ready !== 2'b00) begin
      n_fail++; $display("FAIL rm_abort got=%b/%b exp=00000/00", ctl, ready);
    end
    HRESETn = 1'b1;
    valid[1] = 1'b1; addr[1] = 16'h0300; wr[1] = 1'b1; apb.PREADY = 1'b1;
    step();
    n_checks++; if (ready !== 2'b00) begin n_fail++; $display("FAIL rm_no_ready got=%b exp=00", ready); end
    n_checks++; if (ctl !== 5'b10011) begin n_fail++; $display("FAIL rm_tie got=%b exp=10011", ctl); end
    do_reset();
  endtask

  task automatic test_random();
    logic [4:0]    exp_ctl;
    logic [AW-1:0] exp_addr;
    do_reset();
    m_phase = 0; m_owner = 0; m_last = 1; m_wait = 0; m_ready = 2'b00;
    for (int c = 0; c < 800; c++) begin
      PCLKEN = ($urandom_range(0, 9) < 7);
      apb.PREADY = ($urandom_range(0, 9) < 5);
      apb.PSLVERR = ($urandom_range(0, 4) == 0);
      apb.PRDATA = $urandom();
      for (int n = 0; n < 2; n++) begin
        if (!valid[n] && $urandom_range(0, 2) == 0) begin
          valid[n] = 1'b1; addr[n] = AW'($urandom()); wr[n] = 1'($urandom_range(0, 1));
          wdata[n] = $urandom(); strb[n] = 4'($urandom_range(0, 15));
        end
      end
      step();
      model_step(PCLKEN, valid, apb.PREADY, apb.PSLVERR, apb.PRDATA);
      exp_ctl = {m_phase != 0, m_phase == 2, (m_phase != 0) && (m_owner == 1),
                 (m_phase != 0) && (m_owner == 0), m_phase != 0};
      n_checks++; if (ctl !== exp_ctl) begin
        n_fail++; $display("FAIL rnd_ctl c=%0d got=%b exp=%b", c, ctl, exp_ctl);
      end
      n_checks++; if (ready !== m_ready) begin
        n_fail++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, ready, m_ready);
      end
      for (int n = 0; n < 2; n++) begin
        if (m_ready[n]) begin
          n_checks++; if (rdata[n] !== m_rdata || err[n] !== m_err) begin
            n_fail++; $display("FAIL rnd_resp c=%0d n=%0d got=%h/%b exp=%h/%b", c, n, rdata[n],
                               err[n], m_rdata, m_err);
          end
        end
      end
      if (m_phase != 0) begin
        exp_addr = addr[m_owner] & 16'hFFFC;
        n_checks++; if (apb.PADDR !== exp_addr || apb.PWRITE !== wr[m_owner]) begin
          n_fail++; $display("FAIL rnd_addr c=%0d got=%h/%b exp=%h/%b", c, apb.PADDR, apb.PWRITE,
                             exp_addr, wr[m_owner]);
        end
        n_checks++; if (apb.PWDATA !== wdata[m_owner] ||
                        apb.PSTRB !== (wr[m_owner] ? strb[m_owner] : 4'h0)) begin
          n_fail++; $display("FAIL rnd_wdata c=%0d got=%h/%h exp=%h/%h", c, apb.PWDATA, apb.PSTRB,
                             wdata[m_owner], wr[m_owner] ? strb[m_owner] : 4'h0);
        end
      end
      for (int n = 0; n < 2; n++) begin
        if (m_ready[n]) valid[n] = 1'b0;
      end
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_back_to_back();
    test_pclken_stall();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 The block SHALL expose parameter ADDRWIDTH, default 16, giving the APB address width.
REQ-002 The block SHALL expose parameter DATAWIDTH, default 32, giving the data width.
REQ-003 The block SHALL expose parameter TIMEOUT, default 255, giving the number of PCLKEN-qualified wait cycles before abort; 0 disables the timeout.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset: HCLK  input  1  sole clock; all logic is on the rising edge.
REQ-005 HRESETn  input  1  synchronous active-low reset, sampled on the HCLK rising edge.
REQ-006 PCLKEN  input  1  APB clock enable; APB-side state advances only on HCLK edges where PCLKEN=1.
REQ-007 REQn_VALID  input  1  request from requester n (n=0,1).
REQ-008 REQn_ADDR  input  ADDRWIDTH  request address.
REQ-009 REQn_WRITE  input  1  1 selects write, 0 selects read.
REQ-010 REQn_WDATA  input  DATAWIDTH  write data.
REQ-011 REQn_STRB  input  4  write byte strobes.
REQ-012 REQn_READY  output  1  one-HCLK completion pulse.
REQ-013 REQn_RDATA  output  DATAWIDTH  read data, valid while REQn_READY=1.
REQ-014 REQn_ERR  output  1  error flag, valid while REQn_READY=1.
REQ-015 PSEL, PENABLE, PWRITE  output  1 each  APB control.
REQ-016 PADDR  output  ADDRWIDTH  APB address, word-aligned.
REQ-017 PWDATA  output  DATAWIDTH  APB write data.
REQ-018 PSTRB  output  4  APB byte strobes.
REQ-019 PRDATA  input  DATAWIDTH  APB read data.
REQ-020 PREADY, PSLVERR  input  1 each  APB completion and error.
REQ-021 GRANT  output  2  one-hot current owner, 00 when idle.
REQ-022 BUSY  output  1  1 in any state other than IDLE.

Function
REQ-023 The block SHALL implement the states IDLE, SETUP and ACCESS; every transition requires PCLKEN=1.
REQ-024 IDLE: when any REQn_VALID=1, arbitrate, latch the winner's ADDR/WRITE/WDATA/STRB and GRANT, then go to SETUP.
REQ-025 SETUP: drive PSEL=1 and PENABLE=0, then go to ACCESS.
REQ-026 ACCESS: drive PSEL=1 and PENABLE=1; with PREADY=1, complete the transfer.
REQ-027 On completion, the block SHALL pulse REQn_READY for exactly one HCLK, with REQn_RDATA=PRDATA (reads) or 0 (writes) and REQn_ERR=PSLVERR.
REQ-028 On completion, if the other requester's VALID=1, the block SHALL go directly to SETUP with that requester granted (back-to-back, no IDLE cycle); otherwise it SHALL go to IDLE.
REQ-029 The completing requester's VALID SHALL be ignored in its completion cycle.
REQ-030 Arbitration SHALL be 2-way round-robin: on simultaneous requests, grant the requester not most recently granted; the last-grant pointer resets to 1, so REQ0 wins the first tie.
REQ-031 The requester SHALL hold VALID and its payload stable until READY; the block SHALL use only the latched payload after grant.
REQ-032 PADDR SHALL equal {ADDR[ADDRWIDTH-1:2],2'b00}.
REQ-033 PSTRB SHALL be 0 on reads; PWDATA SHALL hold the latched value.
REQ-034 When TIMEOUT≠0, a wait counter SHALL count ACCESS cycles with PCLKEN=1 and PREADY=0.
REQ-035 When the wait counter reaches TIMEOUT, the block SHALL complete the transfer with ERR=1 and RDATA=0, drop PSEL, and clear the counter.
REQ-036 The wait counter SHALL clear on every grant.
REQ-037 Cycles with PCLKEN=0 SHALL freeze state, APB outputs and the counter.
REQ-038 All outputs SHALL be registered, except that GRANT and BUSY SHALL be decoded from state registers.

Reset
REQ-039 When HRESETn=0 at an HCLK edge, the block SHALL enter IDLE regardless of PCLKEN.
REQ-040 Reset SHALL force all outputs to 0, the wait counter to 0 and the pointer to 1.
REQ-041 A reset asserted mid-transfer SHALL abandon the transfer with no READY pulse; PSEL drops at that edge.

Structure
REQ-042 Package apb_arb_pkg SHALL hold the state enum (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10) and the default width constants.
REQ-043 The block SHALL instantiate sub-module apb_rr_arbiter, a 2-way round-robin arbiter holding the pointer and producing the one-hot grant.

Verification
REQ-044 Single read: PCLKEN=1 throughout, REQ0 read at 0x0013, PREADY=1, PRDATA=0xCAFE0001 -> PADDR=0x0010, SETUP then ACCESS, REQ0_READY at the 3rd edge, RDATA=0xCAFE0001, ERR=0.
REQ-045 Simultaneous requests after reset: REQ0 and REQ1 both write -> REQ0 served first, REQ1 back-to-back with no IDLE cycle, GRANT 01 then 10; PSTRB follows STRB.
REQ-046 PCLKEN=1 every 2nd cycle, PREADY low for 3 enabled cycles -> ACCESS held for exactly 3 enabled cycles plus the completing one; all outputs frozen on PCLKEN=0 cycles.
REQ-047 TIMEOUT=4, PREADY stuck at 0 -> ERR=1 and RDATA=0 after 4 enabled wait cycles, then IDLE.
REQ-048 HRESETn=0 during ACCESS -> next edge PSEL=PENABLE=0, no READY pulse; the next tie goes to REQ0.
